// File: rtl/ps2_mon_fmt_pkg.sv
// Shared constants, types and text helpers for the PS/2 monitor text formatter.
package ps2_mon_fmt_pkg;

    localparam int MAX_SEL_NUM = 9;
    localparam int SEL_IW      = $clog2(MAX_SEL_NUM);
    localparam int CMT_TXT_LEN = 16;
    localparam int DATA_LEN    = 10;
    localparam int CMT_LEN     = CMT_TXT_LEN + 4;
    localparam int CAP_DEPTH   = 2;

    localparam int RESET_CMD = 0;
    localparam int ACK       = 1;
    localparam int RESEND    = 2;
    localparam int ERROR     = 3;
    localparam int BAT_OK    = 4;
    localparam int DEV_ID    = 5;
    localparam int BYTE_1    = 6;
    localparam int BYTE_2    = 7;
    localparam int BYTE_3    = 8;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_A  = 8'h41;

    localparam logic [63:0] HOST_PFX = "HOST: 0x";
    localparam logic [63:0] DEV_PFX  = "DEV : 0x";

    typedef logic [CMT_TXT_LEN*8-1:0] cmt_txt_t;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } cap_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_DATA_END,
        ST_CMT,
        ST_CMT_END
    } fmt_state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? ASC_0 + {4'h0, n} : ASC_A + {4'h0, n} - 8'd10;
    endfunction

    // Lowest set bit wins; no bit set yields MAX_SEL_NUM (the "?" entry).
    function automatic int unsigned sel_index(input logic [MAX_SEL_NUM-1:0] sel);
        int unsigned idx;
        idx = MAX_SEL_NUM;
        for (int unsigned i = MAX_SEL_NUM; i > 0; i--) begin
            if (sel[SEL_IW'(i - 1)]) idx = i - 1;
        end
        return idx;
    endfunction

    function automatic cmt_txt_t cmt_text(input int unsigned sel);
        case (sel)
            RESET_CMD: return "RESET           ";
            ACK:       return "ACK             ";
            RESEND:    return "RESEND          ";
            ERROR:     return "ERROR           ";
            BAT_OK:    return "BAT OK          ";
            DEV_ID:    return "DEVICE ID       ";
            BYTE_1:    return "BYTE 1          ";
            BYTE_2:    return "BYTE 2          ";
            BYTE_3:    return "BYTE 3          ";
            default:   return "?               ";
        endcase
    endfunction

endpackage

// File: rtl/ps2_mon_fmt_if.sv
// Capture, command-monitor handshake and UART write signals of the formatter.
interface ps2_mon_fmt_if;
    import ps2_mon_fmt_pkg::*;

    logic                   ps2_wr_stb;
    logic [7:0]             ps2_wr_data;
    logic                   ps2_rddata_valid;
    logic [7:0]             ps2_rd_data;
    logic                   host_data_xfr;
    logic                   device_data_xfr;
    logic                   comment_data_xfr;
    logic                   data_xfr_int;
    logic [MAX_SEL_NUM-1:0] comment_sel;
    logic                   host_data_start;
    logic                   device_data_start;
    logic                   char_idx_end;
    logic                   uart_wr_en;
    logic [7:0]             uart_wr_data;
    logic                   cap_overflow;

    modport master (
        output ps2_wr_stb, ps2_wr_data, ps2_rddata_valid, ps2_rd_data,
               host_data_xfr, device_data_xfr, comment_data_xfr,
               data_xfr_int, comment_sel,
        input  host_data_start, device_data_start, char_idx_end,
               uart_wr_en, uart_wr_data, cap_overflow
    );

    modport slave (
        input  ps2_wr_stb, ps2_wr_data, ps2_rddata_valid, ps2_rd_data,
               host_data_xfr, device_data_xfr, comment_data_xfr,
               data_xfr_int, comment_sel,
        output host_data_start, device_data_start, char_idx_end,
               uart_wr_en, uart_wr_data, cap_overflow
    );

endinterface

// File: rtl/ps2_mon_capq.sv
// Capture FIFO of {src, byte} entries; accepts a host and a device push per cycle.
module ps2_mon_capq
    import ps2_mon_fmt_pkg::*;
#(
    parameter int DEPTH = CAP_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_host_i,
    input  logic [7:0] host_byte_i,
    input  logic       push_dev_i,
    input  logic [7:0] dev_byte_i,
    input  logic       pop_i,
    output logic       empty_o,
    output cap_entry_t head_o,
    output logic       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    cap_entry_t mem_q [DEPTH];
    ptr_t       wr_q, rd_q;
    cnt_t       cnt_q, free;
    logic       pop_ok, host_ok, dev_ok, ovf_q;

    // A pop frees its slot for a push in the same cycle; host takes space first.
    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        free    = cnt_t'(DEPTH) - cnt_q + cnt_t'(pop_ok);
        host_ok = push_host_i && (free != '0);
        dev_ok  = push_dev_i && (free > cnt_t'(host_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_q + ptr_t'(host_ok) + ptr_t'(dev_ok);
            rd_q  <= rd_q + ptr_t'(pop_ok);
            cnt_q <= cnt_q + cnt_t'(host_ok) + cnt_t'(dev_ok) - cnt_t'(pop_ok);
            ovf_q <= ovf_q | (push_host_i & ~host_ok) | (push_dev_i & ~dev_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (host_ok) mem_q[wr_q] <= '{src: 1'b0, data: host_byte_i};
        if (dev_ok)  mem_q[wr_q + ptr_t'(host_ok)] <= '{src: 1'b1, data: dev_byte_i};
    end

    assign empty_o    = (cnt_q == '0);
    assign head_o     = mem_q[rd_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_mon_fmt.sv
// Formats each captured PS/2 byte as a data field plus comment field onto the UART.
module ps2_mon_fmt
    import ps2_mon_fmt_pkg::*;
(
    input logic          clk,
    input logic          rst,
    ps2_mon_fmt_if.slave bus
);

    fmt_state_e state_q, state_d;
    cap_entry_t line_q, line_d, head;
    logic [4:0] idx_q, idx_d;
    cmt_txt_t   txt_q, txt_d, txt_sh;
    logic [63:0] pfx, pfx_sh;
    logic [7:0] wr_data_q, wr_data_d, data_ch, cmt_ch;
    logic       wr_en_q, wr_en_d, hs_q, hs_d, ds_q, ds_d, end_q, end_d;
    logic       empty, pop, xfr_ok, cmt_ok;

    ps2_mon_capq #(.DEPTH(CAP_DEPTH)) u_capq (
        .clk         (clk),
        .rst         (rst),
        .push_host_i (bus.ps2_wr_stb),
        .host_byte_i (bus.ps2_wr_data),
        .push_dev_i  (bus.ps2_rddata_valid),
        .dev_byte_i  (bus.ps2_rd_data),
        .pop_i       (pop),
        .empty_o     (empty),
        .head_o      (head),
        .overflow_o  (bus.cap_overflow)
    );

    always_comb begin
        pfx    = line_q.src ? DEV_PFX : HOST_PFX;
        pfx_sh = pfx << {idx_q, 3'b000};
        txt_sh = txt_q << {idx_q - 5'd2, 3'b000};

        if (idx_q < 5'(DATA_LEN - 2))       data_ch = pfx_sh[63:56];
        else if (idx_q == 5'(DATA_LEN - 2)) data_ch = hex_char(line_q.data[7:4]);
        else                                data_ch = hex_char(line_q.data[3:0]);

        if (idx_q < 5'd2)                  cmt_ch = ASC_SP;
        else if (idx_q < 5'(CMT_LEN - 2))  cmt_ch = txt_sh[CMT_TXT_LEN*8-1 -: 8];
        else if (idx_q == 5'(CMT_LEN - 2)) cmt_ch = ASC_CR;
        else                               cmt_ch = ASC_LF;

        xfr_ok = bus.data_xfr_int && (bus.host_data_xfr || bus.device_data_xfr);
        cmt_ok = bus.data_xfr_int && bus.comment_data_xfr;
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        idx_d     = idx_q;
        txt_d     = txt_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    line_d  = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                idx_d   = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (xfr_ok) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = data_ch;
                    idx_d     = idx_q + 5'd1;
                    if (idx_q == 5'(DATA_LEN - 1)) state_d = ST_DATA_END;
                end
            end
            ST_DATA_END: begin
                idx_d   = '0;
                txt_d   = cmt_text(sel_index(bus.comment_sel));
                state_d = ST_CMT;
            end
            ST_CMT: begin
                if (cmt_ok) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = cmt_ch;
                    idx_d     = idx_q + 5'd1;
                    if (idx_q == 5'(CMT_LEN - 1)) state_d = ST_CMT_END;
                end
            end
            ST_CMT_END: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // Pulses are registered from the next state so they align with the state itself.
        hs_d  = (state_d == ST_START) && !line_d.src;
        ds_d  = (state_d == ST_START) && line_d.src;
        end_d = (state_d == ST_DATA_END) || (state_d == ST_CMT_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            idx_q     <= '0;
            txt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            hs_q      <= 1'b0;
            ds_q      <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            idx_q     <= idx_d;
            txt_q     <= txt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            hs_q      <= hs_d;
            ds_q      <= ds_d;
            end_q     <= end_d;
        end
    end

    assign bus.host_data_start   = hs_q;
    assign bus.device_data_start = ds_q;
    assign bus.char_idx_end      = end_q;
    assign bus.uart_wr_en        = wr_en_q;
    assign bus.uart_wr_data      = wr_data_q;

endmodule

// File: tb/tb_ps2_mon_fmt.sv
// Self-checking bench for ps2_mon_fmt against a string-level model of each printed line.
module tb_ps2_mon_fmt;
    import ps2_mon_fmt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    ps2_mon_fmt_if bus ();

    ps2_mon_fmt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         hs_cyc[$];
    int         ds_cyc[$];
    int         end_cyc[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.uart_wr_en === 1'b1) begin
            got_q.push_back(bus.uart_wr_data);
            got_cyc.push_back(cyc);
        end
        if (bus.host_data_start === 1'b1)   hs_cyc.push_back(cyc);
        if (bus.device_data_start === 1'b1) ds_cyc.push_back(cyc);
        if (bus.char_idx_end === 1'b1)      end_cyc.push_back(cyc);
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    string cmt_names[MAX_SEL_NUM] = '{"RESET", "ACK", "RESEND", "ERROR", "BAT OK",
                                      "DEVICE ID", "BYTE 1", "BYTE 2", "BYTE 3"};

    function automatic logic [7:0] hexdig(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Expected printed line: 10-char data field then "  " + padded comment + CR LF.
    function automatic void add_line(input bit src, input logic [7:0] b,
                                     input logic [MAX_SEL_NUM-1:0] sel);
        string s;
        string t;
        int    k;
        s = src ? "DEV : 0x" : "HOST: 0x";
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
        exp_q.push_back(hexdig(int'(b) / 16));
        exp_q.push_back(hexdig(int'(b) % 16));
        k = -1;
        for (int i = MAX_SEL_NUM - 1; i >= 0; i--) if (sel[i]) k = i;
        t = (k >= 0) ? cmt_names[k] : "?";
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h20);
        for (int i = 0; i < CMT_TXT_LEN; i++) exp_q.push_back((i < t.len()) ? t[i] : 8'h20);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    task automatic clear_log();
        got_q.delete(); got_cyc.delete(); hs_cyc.delete();
        ds_cyc.delete(); end_cyc.delete(); exp_q.delete();
    endtask

    task automatic send(input bit src, input logic [7:0] b, output int k0);
        @(posedge clk); #1;
        k0 = cyc;
        if (src) begin
            bus.ps2_rddata_valid = 1'b1;
            bus.ps2_rd_data      = b;
        end else begin
            bus.ps2_wr_stb  = 1'b1;
            bus.ps2_wr_data = b;
        end
        @(posedge clk); #1;
        bus.ps2_wr_stb       = 1'b0;
        bus.ps2_rddata_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_cmp += 6;
        if (bus.uart_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", bus.uart_wr_en); end
        if (bus.uart_wr_data !== 8'h00) begin n_err++; $display("FAIL rst_wr_data: got %h want 00", bus.uart_wr_data); end
        if (bus.host_data_start !== 1'b0) begin n_err++; $display("FAIL rst_hs: got %b want 0", bus.host_data_start); end
        if (bus.device_data_start !== 1'b0) begin n_err++; $display("FAIL rst_ds: got %b want 0", bus.device_data_start); end
        if (bus.char_idx_end !== 1'b0) begin n_err++; $display("FAIL rst_end: got %b want 0", bus.char_idx_end); end
        if (bus.cap_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", bus.cap_overflow); end
        rst = 1'b0;
    endtask

    task automatic test_host_line();
        int k0;
        int bad;
        clear_log();
        bus.comment_sel = MAX_SEL_NUM'(1 << RESET_CMD);
        add_line(1'b0, 8'hFF, bus.comment_sel);
        send(1'b0, 8'hFF, k0);
        wait_writes(DATA_LEN + CMT_LEN, 200);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL host_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_cmp++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin n_err++; $display("FAIL host_stream idx %0d: got %h want %h", bad, (bad < got_q.size()) ? got_q[bad] : 8'hxx, exp_q[bad]); end
        n_cmp++;
        if (hs_cyc.size() != 1 || hs_cyc[0] != k0 + 2) begin n_err++; $display("FAIL host_start: got %0d pulses first at %0d want 1 at %0d", hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] - k0 : -1, 2); end
        n_cmp++;
        if (got_cyc.size() == 0 || got_cyc[0] != k0 + 4) begin n_err++; $display("FAIL host_first_char: got +%0d want +4", (got_cyc.size() > 0) ? got_cyc[0] - k0 : -1); end
        n_cmp++;
        if (end_cyc.size() != 2 || end_cyc[0] != k0 + 13 || end_cyc[1] != k0 + 34) begin n_err++; $display("FAIL host_idx_end: got %0d pulses, first +%0d want 2 at +13,+34", end_cyc.size(), (end_cyc.size() > 0) ? end_cyc[0] - k0 : -1); end
        n_cmp++;
        if (ds_cyc.size() != 0) begin n_err++; $display("FAIL host_no_ds: got %0d device starts want 0", ds_cyc.size()); end
    endtask

    task automatic test_dev_ack();
        int k0;
        int bad;
        clear_log();
        bus.comment_sel = MAX_SEL_NUM'(1 << ACK);
        add_line(1'b1, 8'hFA, bus.comment_sel);
        send(1'b1, 8'hFA, k0);
        wait_writes(DATA_LEN + CMT_LEN, 200);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad >= 0 || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL dev_stream idx %0d: got %0d chars want %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++;
        if (ds_cyc.size() != 1) begin n_err++; $display("FAIL dev_start_width: got %0d cycles want 1", ds_cyc.size()); end
        n_cmp++;
        if (ds_cyc.size() == 0 || ds_cyc[0] != k0 + 2) begin n_err++; $display("FAIL dev_start_time: got +%0d want +2", (ds_cyc.size() > 0) ? ds_cyc[0] - k0 : -1); end
        n_cmp++;
        if (hs_cyc.size() != 0) begin n_err++; $display("FAIL dev_no_hs: got %0d host starts want 0", hs_cyc.size()); end
    endtask

    task automatic test_random_throttle();
        for (int it = 0; it < 4; it++) begin
            int k0;
            int bad;
            bit src;
            logic [7:0] b;
            clear_log();
            src = 1'($urandom_range(0, 1));
            b   = 8'($urandom_range(0, 255));
            bus.comment_sel = MAX_SEL_NUM'($urandom_range(1, (1 << MAX_SEL_NUM) - 1));
            add_line(src, b, bus.comment_sel);
            send(src, b, k0);
            for (int c = 0; c < 1500 && !(got_q.size() >= DATA_LEN + CMT_LEN && end_cyc.size() >= 2); c++) begin
                @(posedge clk); #1;
                bus.data_xfr_int     = 1'($urandom_range(0, 1));
                bus.host_data_xfr    = 1'($urandom_range(0, 3) != 0);
                bus.device_data_xfr  = 1'($urandom_range(0, 3) != 0);
                bus.comment_data_xfr = 1'($urandom_range(0, 3) != 0);
            end
            bus.data_xfr_int     = 1'b1;
            bus.host_data_xfr    = 1'b1;
            bus.device_data_xfr  = 1'b1;
            bus.comment_data_xfr = 1'b1;
            repeat (5) @(negedge clk);
            #1;
            n_cmp++;
            if (got_q.size() != DATA_LEN + CMT_LEN) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), DATA_LEN + CMT_LEN); end
            n_cmp++;
            bad = -1;
            for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
            if (bad >= 0) begin n_err++; $display("FAIL rnd%0d_stream idx %0d: got %h want %h", it, bad, (bad < got_q.size()) ? got_q[bad] : 8'hxx, exp_q[bad]); end
            n_cmp++;
            if (end_cyc.size() != 2) begin n_err++; $display("FAIL rnd%0d_idx_end: got %0d pulses want 2", it, end_cyc.size()); end
        end
    endtask

    task automatic test_back_to_back();
        int k0;
        int bad;
        clear_log();
        bus.comment_sel = MAX_SEL_NUM'(1 << BYTE_1);
        add_line(1'b0, 8'h3C, bus.comment_sel);
        add_line(1'b1, 8'h08, bus.comment_sel);
        add_line(1'b1, 8'h01, bus.comment_sel);
        send(1'b0, 8'h3C, k0);
        for (int c = 0; c < 20 && hs_cyc.size() == 0; c++) @(negedge clk);
        @(posedge clk); #1; bus.ps2_rddata_valid = 1'b1; bus.ps2_rd_data = 8'h08;
        @(posedge clk); #1; bus.ps2_rd_data = 8'h01;
        @(posedge clk); #1; bus.ps2_rd_data = 8'h02;
        @(posedge clk); #1; bus.ps2_rddata_valid = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (bus.cap_overflow !== 1'b1) begin n_err++; $display("FAIL b2b_overflow_set: got %b want 1", bus.cap_overflow); end
        wait_writes(3 * (DATA_LEN + CMT_LEN), 600);
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        n_cmp++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad >= 0) begin n_err++; $display("FAIL b2b_stream idx %0d: got %h want %h", bad, (bad < got_q.size()) ? got_q[bad] : 8'hxx, exp_q[bad]); end
        n_cmp++;
        if (ds_cyc.size() != 2) begin n_err++; $display("FAIL b2b_dev_lines: got %0d want 2", ds_cyc.size()); end
        n_cmp++;
        if (bus.cap_overflow !== 1'b1) begin n_err++; $display("FAIL b2b_overflow_sticky: got %b want 1", bus.cap_overflow); end
    endtask

    task automatic test_mid_reset();
        int k0;
        int k1;
        clear_log();
        bus.comment_sel = MAX_SEL_NUM'(1 << RESEND);
        send(1'b0, 8'($urandom_range(0, 255)), k0);
        send(1'b1, 8'h55, k1);
        wait_writes(4, 100);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp += 7;
        if (got_q.size() != 4) begin n_err++; $display("FAIL mrst_writes: got %0d want 4", got_q.size()); end
        if (bus.uart_wr_en !== 1'b0) begin n_err++; $display("FAIL mrst_wr_en: got %b want 0", bus.uart_wr_en); end
        if (bus.uart_wr_data !== 8'h00) begin n_err++; $display("FAIL mrst_wr_data: got %h want 00", bus.uart_wr_data); end
        if (bus.host_data_start !== 1'b0) begin n_err++; $display("FAIL mrst_hs: got %b want 0", bus.host_data_start); end
        if (bus.device_data_start !== 1'b0) begin n_err++; $display("FAIL mrst_ds: got %b want 0", bus.device_data_start); end
        if (bus.char_idx_end !== 1'b0) begin n_err++; $display("FAIL mrst_end: got %b want 0", bus.char_idx_end); end
        if (bus.cap_overflow !== 1'b0) begin n_err++; $display("FAIL mrst_ovf: got %b want 0", bus.cap_overflow); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != 4 || ds_cyc.size() != 0) begin n_err++; $display("FAIL mrst_quiet: got %0d writes %0d dev starts want 4 and 0", got_q.size(), ds_cyc.size()); end
    endtask

    task automatic test_unknown_sel();
        int k0;
        int bad;
        logic [7:0] b;
        clear_log();
        b = 8'($urandom_range(0, 255));
        bus.comment_sel = '0;
        add_line(1'b0, b, bus.comment_sel);
        send(1'b0, b, k0);
        wait_writes(DATA_LEN + CMT_LEN, 200);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad >= 0 || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL unk_stream idx %0d: got %0d chars want %0d", bad, got_q.size(), exp_q.size()); end
        n_cmp++;
        if (end_cyc.size() != 2) begin n_err++; $display("FAIL unk_idx_end: got %0d pulses want 2", end_cyc.size()); end
    endtask

    initial begin
        bus.ps2_wr_stb       = 1'b0;
        bus.ps2_wr_data      = '0;
        bus.ps2_rddata_valid = 1'b0;
        bus.ps2_rd_data      = '0;
        bus.host_data_xfr    = 1'b1;
        bus.device_data_xfr  = 1'b1;
        bus.comment_data_xfr = 1'b1;
        bus.data_xfr_int     = 1'b1;
        bus.comment_sel      = '0;
        test_reset();
        test_host_line();
        test_dev_ack();
        test_random_throttle();
        test_back_to_back();
        test_mid_reset();
        test_unknown_sel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_mon_fmt.md
Name: ps2_mon_fmt

Overview:
- Downstream text formatter for the PS/2 host monitor path.
- Captures every host-to-device byte (ps2_wr_stb) and every device-to-host byte (ps2_rddata_valid).
- Drives the start/end handshake that the command monitor's xfr flags respond to.
- Serialises one 10-char data field, then one comment field selected by comment_sel, into the UART write port, one char per data_xfr_int cycle.

Parameters:
- MAX_SEL_NUM, `MAX_SEL_NUM (ps2_define.vh): width of comment_sel.
- CMT_TXT_LEN, 16: comment text chars; comment field = 2 spaces + text + CR LF = CMT_TXT_LEN+4.
- CAP_DEPTH, 2: capture queue depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ps2_wr_stb  in  1  host byte sent
- ps2_wr_data  in  8  host byte
- ps2_rddata_valid  in  1  device byte received
- ps2_rd_data  in  8  device byte
- host_data_xfr  in  1  host field phase active (from command monitor)
- device_data_xfr  in  1  device field phase active
- comment_data_xfr  in  1  comment phase active
- data_xfr_int  in  1  one char may be emitted this cycle (UART ready qualified)
- comment_sel  in  MAX_SEL_NUM  one-hot comment index
- host_data_start  out  1  1-cycle pulse, begin host field
- device_data_start  out  1  1-cycle pulse, begin device field
- char_idx_end  out  1  1-cycle pulse, current field finished
- uart_wr_en  out  1  UART push
- uart_wr_data  out  8  ASCII char
- cap_overflow  out  1  sticky, byte dropped

Behaviour:
- Reset is synchronous; clk and rst are as already decided.
- All outputs reset to 0. Reset clears the FSM, char index, queue and overflow. Reset mid-line abandons the line; no further UART writes.
- Capture queue holds entries {src, byte}, with src 0 = host, 1 = device.
  - Pushed on ps2_wr_stb (src 0) or ps2_rddata_valid (src 1).
  - If both fire in one cycle, the host entry is pushed first; the device entry is pushed the same cycle if space remains, else dropped.
  - Push when full drops the byte and sets cap_overflow (sticky).
  - A pop and a push in the same cycle are both honoured.
- FSM states: IDLE, START, DATA, DATA_END, CMT, CMT_END.
  - IDLE: queue not empty -> pop into line register, go to START.
  - START: pulse host_data_start (src 0) or device_data_start (src 1) for 1 cycle, clear char index, go to DATA.
  - DATA: on each cycle with data_xfr_int=1 and (host_data_xfr|device_data_xfr)=1, emit char[idx] and increment idx.
    - Host field text: "HOST: 0x" + 2 upper-case hex digits.
    - Device field text: "DEV : 0x" + 2 hex digits.
    - After idx 9 is emitted, go to DATA_END.
  - DATA_END: char_idx_end=1 for exactly 1 cycle; data_xfr_int is ignored in this cycle. Clear idx, go to CMT. The command monitor sets comment_data_xfr in the same edge.
  - CMT: on each cycle with data_xfr_int=1 and comment_data_xfr=1, emit the comment char.
    - Comment text = ROM[priority_encode(comment_sel)], latched on entry to CMT.
    - comment_sel == 0 on entry selects the "?" entry.
    - After the last char (LF) is emitted, go to CMT_END.
  - CMT_END: char_idx_end=1 for 1 cycle, data_xfr_int ignored, go to IDLE.
- char_idx_end is a registered pulse, never combinational from data_xfr_int (avoids a loop through the command monitor).
- uart_wr_en / uart_wr_data are registered: char emitted at cycle n appears at cycle n+1. uart_wr_en is never high for 2 cycles from a single data_xfr_int event.
- Hex digits: nibble 0-9 -> 0x30+n; A-F -> 0x41+n-10.
- Minimum time from queue-not-empty to first char: 2 cycles (IDLE, START).
- comment_data_xfr low while in CMT: stall; no timeout.

Decomposition:
- Shared ps2_pkg.vh gains:
  - the ASCII constants;
  - a comment text ROM function, sel index -> CMT_TXT_LEN-char string, using the existing RESET_CMD..BYTE_3 indices plus a "?" default;
  - the field length constants (DATA_LEN=10, CMT_LEN).
- Sub-module ps2_mon_capq: the CAP_DEPTH {src, byte} FIFO with the overflow flag.

Test Plan:
- ps2_wr_stb, data 0xFF, UART always ready:
  - host_data_start at +2;
  - UART receives "HOST: 0xFF" (10 writes), then char_idx_end;
  - then "  RESET..." comment + CR LF, then a second char_idx_end;
  - FSM returns to IDLE.
- ps2_rddata_valid, data 0xFA, ACK selected -> "DEV : 0xFA" followed by the ACK comment; the device_data_start pulse is exactly 1 cycle.
- data_xfr_int toggled 1-0-1 randomly during a line -> exactly 10 + CMT_LEN writes, in order, no duplicates.
- Three device bytes 0x08, 0x01, 0x02 arrive back-to-back while the first line is printing:
  - queue holds 2 entries;
  - the third byte sets cap_overflow;
  - the printed sequence is 0x08 then 0x01.
- rst asserted in mid-DATA at idx 4 -> next cycle all outputs 0, no further UART writes, queue empty.
- comment_sel = 0 on entry to CMT -> the "?" comment is emitted and the line terminates normally.
